grid_frame_tx: RTL

- Transmit side of the board-observation interface.
- Takes a snapshot of the flat ROWS×COLS `grid` vector produced by the game-of-life core (`main`) and sends it out one row per beat over a valid/ready stream.
- Row order is row 0 = grid[COLS-1:0] first, up to row ROWS-1, the same row order used when dumping the board.
- Feeds a downstream logger, UART bridge or display writer, and lets the core keep evolving while a stable frame is sent.

---
 rtl/grid_frame_tx.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/grid_frame_tx.sv
`default_nettype none
// ============================================================================
// Module  : grid_frame_tx
// Purpose : Takes a snapshot of the ROWS x COLS game-of-life board and sends
//           it one row per beat over a valid/ready stream. Row 0, which is
//           grid[COLS-1:0], is sent first. The core can keep evolving while a
//           stable frame is sent. A snap request made while a frame is in
//           flight is held as one pending frame.
// Ports   : clk, reset (async, active-high)
//           snap        - capture request, level sampled every cycle
//           grid        - live board, cell (r,c) = grid[r*COLS+c]
//           busy        - frame held or being sent (SEND, DONE)
//           row_valid / row_ready / row_data / row_idx / row_last - row stream
//           frame_done  - one-cycle pulse after the last row is accepted
//           frame_count - completed frames, wraps at 2^CNT_W
// Revision: 1.0 - initial release
// ============================================================================
module grid_frame_tx #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     snap,
  input  logic [ROWS*COLS-1:0]     grid,
  output logic                     busy,
  output logic                     row_valid,
  input  logic                     row_ready,
  output logic [COLS-1:0]          row_data,
  output logic [$clog2(ROWS)-1:0]  row_idx,
  output logic                     row_last,
  output logic                     frame_done,
  output logic [CNT_W-1:0]         frame_count
);

  localparam int                IDX_W    = $clog2(ROWS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ROWS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_q;
  logic [ROWS*COLS-1:0]    shadow_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    pending_q;
  logic                    busy_q;
  logic                    valid_q;
  logic [COLS-1:0]         data_q;
  logic                    last_q;
  logic                    done_q;
  logic [CNT_W-1:0]        count_q;

  logic [IDX_W-1:0]        next_idx;

  assign next_idx = idx_q + 1'b1;

  // All stream outputs are registered. When a frame starts, row 0 is taken
  // straight from grid because the shadow copy only becomes valid at the same
  // edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shadow_q  <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (snap) begin
            state_q  <= ST_SEND;
            shadow_q <= grid;
            idx_q    <= '0;
            busy_q   <= 1'b1;
            valid_q  <= 1'b1;
            data_q   <= grid[COLS-1:0];
            last_q   <= (LAST_IDX == '0);
          end
        end

        ST_SEND: begin
          // Any number of snaps during a frame collapse into one pending frame.
          if (snap) begin
            pending_q <= 1'b1;
          end
          if (row_ready) begin
            if (idx_q == LAST_IDX) begin
              state_q <= ST_DONE;
              idx_q   <= '0;
              valid_q <= 1'b0;
              data_q  <= '0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              count_q <= count_q + 1'b1;
            end else begin
              idx_q  <= next_idx;
              data_q <= shadow_q[next_idx*COLS +: COLS];
              last_q <= (next_idx == LAST_IDX);
            end
          end
        end

        ST_DONE: begin
          if (pending_q || snap) begin
            state_q   <= ST_SEND;
            shadow_q  <= grid;
            idx_q     <= '0;
            pending_q <= 1'b0;
            valid_q   <= 1'b1;
            data_q    <= grid[COLS-1:0];
            last_q    <= (LAST_IDX == '0);
          end else begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign row_valid   = valid_q;
  assign row_data    = data_q;
  assign row_idx     = idx_q;
  assign row_last    = last_q;
  assign frame_done  = done_q;
  assign frame_count = count_q;

endmodule
`default_nettype wire
